// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding the instruction memory and the IF/ID register.
// Pairs each returned word with its PC and squashes wrong-path, halt and out-of-range fetches.
`timescale 1ns/1ps

module pc_fetch_unit #(
    parameter int unsigned      NBITS     = 32,
    parameter logic [NBITS-1:0] PC_STEP   = 'd4,
    parameter logic [NBITS-1:0] PC_RESET  = 'd0,
    parameter logic [NBITS-1:0] PC_MAX    = 'd56,
    parameter logic [NBITS-1:0] HALT_WORD = '1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_stall,
    input  logic             i_branch,
    input  logic [NBITS-1:0] i_branch_target,
    input  logic             i_jump,
    input  logic [NBITS-1:0] i_jump_target,
    input  logic [NBITS-1:0] i_instruction,
    output logic [NBITS-1:0] o_PC,
    output logic [NBITS-1:0] o_PC_plus4,
    output logic [NBITS-1:0] o_instr_PC,
    output logic             o_valid,
    output logic             o_halted,
    output logic             o_fault,
    output logic [15:0]      o_instr_count
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt, StFault} state_e;

    state_e           state_q, state_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic [NBITS-1:0] instr_pc_q, instr_pc_d;
    logic             live_q, live_d;
    logic [15:0]      count_q, count_d;

    logic             redirect;
    logic             is_halt_word;
    logic [NBITS-1:0] seq_pc;
    logic [NBITS-1:0] cand_pc;
    logic             seq_bad;
    logic             cand_bad;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= StIdle;
            pc_q       <= PC_RESET;
            instr_pc_q <= PC_RESET;
            live_q     <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            live_q     <= live_d;
            count_q    <= count_d;
        end
    end

    // Carry out of the increment is dropped; the PC_MAX compare catches the wrap.
    assign seq_pc       = pc_q + PC_STEP;
    assign redirect     = i_branch | i_jump;
    assign is_halt_word = (i_instruction == HALT_WORD);
    assign cand_pc      = i_branch ? i_branch_target :
                          i_jump   ? i_jump_target   :
                          i_stall  ? pc_q            : seq_pc;
    assign seq_bad      = (seq_pc[1:0] != 2'b00) || (seq_pc > PC_MAX);
    assign cand_bad     = (cand_pc[1:0] != 2'b00) || (cand_pc > PC_MAX);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        live_d     = live_q;
        count_d    = count_q;
        if (i_enable) begin
            unique case (state_q)
                StIdle: begin
                    live_d     = 1'b1;
                    instr_pc_d = pc_q;
                    if (seq_bad) begin
                        state_d = StFault;
                    end else begin
                        pc_d    = seq_pc;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (o_valid && !i_stall && (count_q != 16'hFFFF)) begin
                        count_d = count_q + 16'd1;
                    end
                    // A redirect squashes a returning halt word rather than halting on it.
                    if (live_q && is_halt_word && !redirect) begin
                        state_d = StHalt;
                    end else if (cand_bad) begin
                        state_d = StFault;
                    end else begin
                        pc_d = cand_pc;
                        if (redirect) begin
                            live_d = 1'b0;
                        end else if (!i_stall) begin
                            live_d     = 1'b1;
                            instr_pc_d = pc_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_PC          = pc_q;
        o_instr_PC    = instr_pc_q;
        o_PC_plus4    = instr_pc_q + PC_STEP;
        o_valid       = live_q && (state_q == StRun) && !is_halt_word;
        o_halted      = (state_q == StHalt);
        o_fault       = (state_q == StFault);
        o_instr_count = count_q;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random redirect/stall/enable traffic,
// compared every cycle against a transaction-level model of the fetch rules.
`timescale 1ns/1ps

module tb_pc_fetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;
    localparam int M_FAULT = 3;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_branch = 1'b0;
    logic [31:0] i_branch_target = '0;
    logic        i_jump = 1'b0;
    logic [31:0] i_jump_target = '0;
    logic [31:0] i_instruction;
    logic [31:0] o_PC, o_PC_plus4, o_instr_PC;
    logic        o_valid, o_halted, o_fault;
    logic [15:0] o_instr_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:14];

    // Model state
    logic [31:0] m_pc, m_ipc, m_instr;
    bit          m_live;
    int          m_mode;
    logic [15:0] m_count;

    pc_fetch_unit dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_enable        (i_enable),
        .i_stall         (i_stall),
        .i_branch        (i_branch),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .i_instruction   (i_instruction),
        .o_PC            (o_PC),
        .o_PC_plus4      (o_PC_plus4),
        .o_instr_PC      (o_instr_PC),
        .o_valid         (o_valid),
        .o_halted        (o_halted),
        .o_fault         (o_fault),
        .o_instr_count   (o_instr_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] fetch(input logic [31:0] a);
        if (a[1:0] == 2'b00 && a <= 32'd56) return mem[a >> 2];
        return 32'h0000_0013;
    endfunction

    // Instruction memory: registered read of the presented address.
    always @(posedge i_clk) i_instruction <= fetch(o_PC);

    function automatic bit exp_valid();
        return m_live && (m_mode == M_RUN) && (m_instr != HALT);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},       o_PC, m_pc);
        chk({tag, ".instr_pc"}, o_instr_PC, m_ipc);
        chk({tag, ".pc_plus4"}, o_PC_plus4, m_ipc + 32'd4);
        chk({tag, ".valid"},    {31'd0, o_valid}, {31'd0, exp_valid()});
        chk({tag, ".halted"},   {31'd0, o_halted}, {31'd0, m_mode == M_HALT});
        chk({tag, ".fault"},    {31'd0, o_fault}, {31'd0, m_mode == M_FAULT});
        chk({tag, ".count"},    {16'd0, o_instr_count}, {16'd0, m_count});
    endtask

    // Apply one cycle's inputs to the model: what the next clock edge should produce.
    task automatic model_edge(input bit en, input bit st, input bit br, input logic [31:0] bt,
                              input bit jp, input logic [31:0] jt);
        logic [31:0] old_pc;
        logic [31:0] nxt;
        old_pc = m_pc;
        if (en && m_mode == M_IDLE) begin
            m_ipc  = m_pc;
            m_live = 1;
            m_pc   = m_pc + 32'd4;
            m_mode = M_RUN;
        end else if (en && m_mode == M_RUN) begin
            if (exp_valid() && !st && m_count != 16'hFFFF) m_count = m_count + 16'd1;
            if (m_live && m_instr == HALT && !(br || jp)) begin
                m_mode = M_HALT;
            end else begin
                nxt = br ? bt : (jp ? jt : (st ? m_pc : m_pc + 32'd4));
                if ((nxt % 4) != 0 || nxt > 32'd56) begin
                    m_mode = M_FAULT;
                end else if (br || jp) begin
                    m_pc   = nxt;
                    m_live = 0;
                end else if (!st) begin
                    m_ipc  = m_pc;
                    m_pc   = nxt;
                    m_live = 1;
                end
            end
        end
        m_instr = fetch(old_pc);
    endtask

    task automatic step(input string tag, input bit en, input bit st, input bit br,
                        input logic [31:0] bt, input bit jp, input logic [31:0] jt);
        @(negedge i_clk);
        i_enable        = en;
        i_stall         = st;
        i_branch        = br;
        i_branch_target = bt;
        i_jump          = jp;
        i_jump_target   = jt;
        model_edge(en, st, br, bt, jp, jt);
        @(posedge i_clk);
        #1;
        check_all(tag);
    endtask

    task automatic run(input string tag);
        step(tag, 1, 0, 0, 32'd0, 0, 32'd0);
    endtask

    // Reset is dropped mid-cycle so the immediate check proves it is asynchronous.
    task automatic do_reset(input string tag);
        @(negedge i_clk);
        i_reset_n = 1'b0;
        i_enable  = 1'b0;
        i_stall   = 1'b0;
        i_branch  = 1'b0;
        i_jump    = 1'b0;
        m_pc      = 32'd0;
        m_ipc     = 32'd0;
        m_live    = 0;
        m_mode    = M_IDLE;
        m_count   = 16'd0;
        #1;
        check_all(tag);
        @(posedge i_clk);
        #1;
        m_instr = fetch(32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    task automatic fill_mem(input int halt_odds);
        for (int k = 0; k < 15; k++) begin
            if (halt_odds > 0 && $urandom_range(0, halt_odds - 1) == 0) mem[k] = HALT;
            else mem[k] = $urandom() & 32'h7FFF_FFFF;
        end
    endtask

    initial begin
        logic [31:0] bt;
        logic [31:0] jt;
        fill_mem(0);

        // Reset and sequential fetch
        do_reset("reset");
        for (int k = 0; k < 3; k++) run("seq");
        chk("seq_at_12", o_PC, 32'd12);

        // Stall holds everything for three cycles, then resumes at 16
        for (int k = 0; k < 3; k++) step("stall", 1, 1, 0, 32'd0, 0, 32'd0);
        run("stall_release");
        chk("resume_16", o_PC, 32'd16);

        // Enable low freezes state and ignores redirects
        step("frozen", 0, 0, 1, 32'd40, 1, 32'd44);

        // Branch from 36 to 52, then sequential overflow past 56 faults
        for (int k = 0; k < 5; k++) run("to36");
        chk("at_36", o_PC, 32'd36);
        step("branch", 1, 0, 1, 32'd52, 0, 32'd0);
        chk("branch_pc", o_PC, 32'd52);
        chk("branch_squash", {31'd0, o_valid}, 32'd0);
        run("after_branch");
        chk("word52_valid", {31'd0, o_valid}, 32'd1);
        run("seq_overflow");
        chk("overflow_fault", {31'd0, o_fault}, 32'd1);
        run("fault_hold");

        // Mid-run asynchronous reset
        do_reset("reset_mid");
        for (int k = 0; k < 3; k++) run("seq2");

        // Branch beats jump; jump beats stall
        step("br_jp", 1, 0, 1, 32'd20, 1, 32'd40);
        chk("br_wins", o_PC, 32'd20);
        run("post_brjp");
        step("jp_stall", 1, 1, 0, 32'd0, 1, 32'd40);
        chk("jp_wins", o_PC, 32'd40);

        // Halt word at PC 0
        mem[0] = HALT;
        do_reset("reset_halt");
        run("halt_fetch");
        chk("halt_not_valid", {31'd0, o_valid}, 32'd0);
        run("halt_enter");
        chk("halted", {31'd0, o_halted}, 32'd1);
        step("halt_frozen", 1, 0, 1, 32'd8, 1, 32'd12);
        chk("halt_pc", o_PC, 32'd4);
        chk("halt_count", {16'd0, o_instr_count}, 32'd0);
        mem[0] = 32'h0000_0013;

        // Halt word squashed by a simultaneous redirect
        mem[3] = HALT;
        do_reset("reset_squash");
        for (int k = 0; k < 4; k++) run("to16");
        step("halt_squash", 1, 0, 0, 32'd0, 1, 32'd0);
        chk("squash_no_halt", {31'd0, o_halted}, 32'd0);
        mem[3] = 32'h0000_0033;

        // Misaligned jump target faults and holds the last legal PC
        do_reset("reset_mis");
        for (int k = 0; k < 2; k++) run("to8");
        step("jump58", 1, 0, 0, 32'd0, 1, 32'd58);
        chk("mis_fault", {31'd0, o_fault}, 32'd1);
        chk("mis_pc", o_PC, 32'd8);

        // Random traffic
        fill_mem(10);
        do_reset("reset_rand");
        for (int i = 0; i < 600; i++) begin
            if ((m_mode == M_HALT || m_mode == M_FAULT) && $urandom_range(0, 3) == 0) begin
                fill_mem(10);
                do_reset("rand_reset");
            end else begin
                bt = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 80))
                                                 : 32'($urandom_range(0, 14) * 4);
                jt = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 80))
                                                 : 32'($urandom_range(0, 14) * 4);
                step("rand",
                     $urandom_range(0, 99) < 85,
                     $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 8, bt,
                     $urandom_range(0, 99) < 8, jt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
